// File: rtl/im_fetch_ctrl_if.sv
// Fetch-side bundle: IM address/data, decode handshake, redirect and fault reporting.
interface im_fetch_ctrl_if;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fault_pc;

  modport master (
    output im_addr, dec_valid, dec_instr, dec_pc, fault, fault_pc,
    input  im_rdata, dec_ready, redirect, redirect_pc
  );

  modport slave (
    input  im_addr, dec_valid, dec_instr, dec_pc, fault, fault_pc,
    output im_rdata, dec_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/im_fetch_ctrl.sv
// Fetch sequencer: owns PC_F, buffers {pc, instr} pairs in a 2-deep ring for decode,
// flushes on redirect and traps fetches outside the IM window.
module im_fetch_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_LAST  = 32'h0000_6FFC
) (
  input  logic            clk,
  input  logic            reset,
  im_fetch_ctrl_if.master bus
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  typedef enum logic {ST_RUN, ST_FAULT} state_e;

  state_e             state_q;
  logic [31:0]        pc_q;
  logic [CNT_W-1:0]   count_q;
  logic               head_q;
  logic               tail_q;
  logic [31:0]        buf_pc_q    [DEPTH];
  logic [31:0]        buf_instr_q [DEPTH];
  logic               fault_q;
  logic [31:0]        fault_pc_q;

  logic legal;
  logic dec_valid;
  logic pop;
  logic push;

  assign legal     = (pc_q[1:0] == 2'b00) && (pc_q >= IM_BASE) && (pc_q <= IM_LAST);
  assign dec_valid = (count_q != '0);
  assign pop       = dec_valid & bus.dec_ready;
  assign push      = (state_q == ST_RUN) & legal &
                     ((count_q < CNT_W'(DEPTH)) | pop) & ~bus.redirect;

  // Head outputs are forced to zero when empty so stale entries never leak.
  assign bus.im_addr   = pc_q;
  assign bus.dec_valid = dec_valid;
  assign bus.dec_pc    = dec_valid ? buf_pc_q[head_q]    : 32'h0;
  assign bus.dec_instr = dec_valid ? buf_instr_q[head_q] : 32'h0;
  assign bus.fault     = fault_q;
  assign bus.fault_pc  = fault_pc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= PC_RESET;
      count_q    <= '0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'h0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        buf_pc_q[i]    <= 32'h0;
        buf_instr_q[i] <= 32'h0;
      end
    end else if (bus.redirect) begin
      // Flush: any head offered this cycle is killed rather than consumed.
      state_q <= ST_RUN;
      pc_q    <= bus.redirect_pc;
      count_q <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (state_q == ST_RUN && !legal) begin
        state_q    <= ST_FAULT;
        fault_q    <= 1'b1;
        fault_pc_q <= pc_q;
      end
      if (push) begin
        buf_pc_q[tail_q]    <= pc_q;
        buf_instr_q[tail_q] <= bus.im_rdata;
        tail_q              <= ~tail_q;
        pc_q                <= pc_q + 32'd4;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule
